line_drawer: RTL and testbench
==============================

LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 Parameter N, default 11, coordinate width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 enable  input  1  high permits line drawing; low holds the block idle.
REQ-005 x0, y0  input  N  start point, unsigned.
REQ-006 x1, y1  input  N  end point, unsigned.
REQ-007 x, y  output  N  current pixel coordinate.
REQ-008 pixel_valid  output  1  high when x,y is a pixel to be written this cycle.
REQ-009 line_done  output  1  one-cycle pulse after the last pixel of a line.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL use four states: IDLE, LOAD, DRAW, DONE.
REQ-012 IDLE: go to LOAD when enable=1, otherwise stay in IDLE.
REQ-013 LOAD (1 cycle): latch the following into internal registers, then go to DRAW:
- x0,y0,x1,y1
- dx=|x1-x0|, dy=-|y1-y0|
- sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
- err=dx+dy
- current x,y = x0,y0
REQ-014 Inputs SHALL be sampled only in LOAD; input changes during DRAW/DONE SHALL have no effect on the line being drawn.
REQ-015 DRAW: pixel_valid=1 every cycle; x,y show the current pixel.
REQ-016 DRAW step, when the current pixel is not the endpoint:
- e2=2*err
- if e2>=dy: err+=dy, x+=sx
- if e2<=dx: err+=dx, y+=sy
- both updates apply in the same cycle when both conditions hold.
REQ-017 DRAW: when current (x,y) equals latched (x1,y1), that pixel is emitted and the next state is DONE.
REQ-018 dx, dy, err and e2 SHALL be signed, N+2 bits wide, with no overflow for any N-bit inputs.
REQ-019 DONE (1 cycle): line_done=1, pixel_valid=0.
REQ-020 Next state from DONE: LOAD if enable=1, else IDLE.
REQ-021 Latency: line length L=max(dx,|dy|).
- LOAD occupies 1 cycle, DRAW occupies L+1 cycles, DONE occupies 1 cycle.
- line_done fires L+2 cycles after LOAD.
- Back-to-back lines with enable held high take L+3 cycles each.
REQ-022 Degenerate line (x0==x1 and y0==y1): exactly one pixel in DRAW, then DONE.
REQ-023 Vertical and horizontal lines in either direction SHALL emit |delta|+1 pixels, monotonic from start to end.
REQ-024 enable deasserted during LOAD or DRAW SHALL NOT abort the line; it takes effect only at the DONE exit.
REQ-025 Handshake: the upstream sequencer presents new coordinates in the cycle after line_done; LOAD samples them in that cycle.
REQ-026 Outside DRAW, x and y SHALL hold their last value; pixel_valid SHALL be 0.

Reset
REQ-027 While reset=0, the block SHALL immediately force state=IDLE and x=0, y=0, pixel_valid=0, line_done=0, busy=0, independent of clk.
REQ-028 Reset asserted mid-line SHALL discard the line with no line_done pulse.
REQ-029 After reset release, the first LOAD SHALL occur on the first clock edge with enable=1.

Verification
REQ-030 Vertical line: (5,10)->(5,14), enable=1 -> pixels (5,10)..(5,14) on 5 consecutive cycles, then line_done for 1 cycle, then LOAD.
REQ-031 Reverse vertical line: (20,30)->(20,27) -> pixels y=30,29,28,27 at x=20, then line_done.
REQ-032 Point: (7,7)->(7,7) -> single pixel (7,7); line_done 2 cycles after LOAD.
REQ-033 Shallow line: (0,0)->(4,2) -> pixels (0,0),(1,1),(2,1),(3,2),(4,2); diagonal (0,0)->(3,3) -> (0,0),(1,1),(2,2),(3,3).
REQ-034 Reset and enable:
- reset=0 on the third DRAW cycle of (0,0)->(0,9) -> outputs 0 immediately, no line_done.
- After release, with enable=1 -> LOAD on the next edge.
- enable=0 at DONE -> IDLE, busy=0.
REQ-035 Input stability: change x1,y1 mid-DRAW -> the pixel sequence matches the coordinates latched at LOAD.

Source files
------------

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches a segment in LOAD, then emits one pixel
// per cycle in DRAW until the latched end point is reached.
module line_drawer #(
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] y0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         pixel_valid,
  output logic         line_done,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [N-1:0]        x_q, x_d, y_q, y_d;
  logic [N-1:0]        x1_q, x1_d, y1_q, y1_d;
  logic signed [N+1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [N+1:0] x_diff, y_diff, x_abs, y_abs, e2, err_step;
  logic                at_end;

  always_comb begin
    x_diff   = $signed({2'b00, x1}) - $signed({2'b00, x0});
    y_diff   = $signed({2'b00, y1}) - $signed({2'b00, y0});
    x_abs    = x_diff[N+1] ? -x_diff : x_diff;
    y_abs    = y_diff[N+1] ? -y_diff : y_diff;
    e2       = err_q <<< 1;
    at_end   = (x_q == x1_q) && (y_q == y1_q);
    err_step = err_q;

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        x1_d     = x1;
        y1_d     = y1;
        x_d      = x0;
        y_d      = y0;
        dx_d     = x_abs;
        dy_d     = -y_abs;
        sx_neg_d = !(x0 < x1);
        sy_neg_d = !(y0 < y1);
        err_d    = x_abs - y_abs;
        state_d  = DRAW;
      end
      DRAW: begin
        if (at_end) begin
          state_d = DONE;
        end else begin
          // Both tests use the pre-step e2 so a diagonal move happens in one cycle.
          if (e2 >= dy_q) begin
            err_step = err_step + dy_q;
            x_d      = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
          end
          if (e2 <= dx_q) begin
            err_step = err_step + dx_q;
            y_d      = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
          end
          err_d = err_step;
        end
      end
      DONE: begin
        state_d = enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  // Status outputs decode the state directly so reset clears them without a clock.
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = (state_q == DRAW);
  assign line_done   = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: hand-computed pixel lists, latency,
// handshake, enable and reset behaviour.
module tb_line_drawer;

  localparam int N = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [N-1:0] x, y;
  logic         pixel_valid, line_done, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_px [16];
  logic [31:0] got_px [$];

  line_drawer #(.N(N)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x(x), .y(y),
    .pixel_valid(pixel_valid), .line_done(line_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] pk(input int px, input int py);
    return {px[15:0], py[15:0]};
  endfunction

  // Called on a negedge; the next posedge enters LOAD (from IDLE or DONE).
  // chg=1 disturbs x1/y1 and drops enable in the middle of DRAW.
  task automatic run_line(input string tag, input int ax0, input int ay0,
                          input int ax1, input int ay1, input int npix,
                          input int len, input bit chg);
    int cyc;
    logic [31:0] g;
    got_px.delete();
    x0 = ax0[N-1:0]; y0 = ay0[N-1:0]; x1 = ax1[N-1:0]; y1 = ay1[N-1:0];
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_val({tag, ".load_busy"}, {31'd0, busy}, 32'd1);
        check_val({tag, ".load_pv"}, {31'd0, pixel_valid}, 32'd0);
        check_val({tag, ".load_done"}, {31'd0, line_done}, 32'd0);
      end
      if (chg && cyc == 3) begin
        x1 = 11'd0; y1 = 11'd0; enable = 1'b0;
      end
      if (pixel_valid) got_px.push_back({5'd0, x, 5'd0, y});
      if (line_done) break;
    end
    check_val({tag, ".done_cycle"}, cyc, len + 3);
    check_val({tag, ".npix"}, got_px.size(), npix);
    for (int i = 0; i < npix; i++) begin
      g = (i < got_px.size()) ? got_px[i] : 32'hFFFF_FFFF;
      check_val($sformatf("%s.px%0d", tag, i), g, exp_px[i]);
    end
    $display("line %s (%0d,%0d)->(%0d,%0d): %0d pixels, done at cycle %0d",
             tag, ax0, ay0, ax1, ay1, got_px.size(), cyc);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check_val("rst.x", {21'd0, x}, 32'd0);
    check_val("rst.y", {21'd0, y}, 32'd0);
    check_val("rst.pv", {31'd0, pixel_valid}, 32'd0);
    check_val("rst.done", {31'd0, line_done}, 32'd0);
    check_val("rst.busy", {31'd0, busy}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("idle.busy", {31'd0, busy}, 32'd0);

    // Vertical, back-to-back lines with enable held high.
    enable = 1'b1;
    exp_px[0] = pk(5, 10); exp_px[1] = pk(5, 11); exp_px[2] = pk(5, 12);
    exp_px[3] = pk(5, 13); exp_px[4] = pk(5, 14);
    run_line("vert", 5, 10, 5, 14, 5, 4, 1'b0);

    exp_px[0] = pk(20, 30); exp_px[1] = pk(20, 29); exp_px[2] = pk(20, 28);
    exp_px[3] = pk(20, 27);
    run_line("rvert", 20, 30, 20, 27, 4, 3, 1'b0);

    exp_px[0] = pk(7, 7);
    run_line("point", 7, 7, 7, 7, 1, 0, 1'b0);

    exp_px[0] = pk(0, 0); exp_px[1] = pk(1, 1); exp_px[2] = pk(2, 1);
    exp_px[3] = pk(3, 2); exp_px[4] = pk(4, 2);
    run_line("shallow", 0, 0, 4, 2, 5, 4, 1'b0);

    exp_px[0] = pk(0, 0); exp_px[1] = pk(1, 1); exp_px[2] = pk(2, 2);
    exp_px[3] = pk(3, 3);
    run_line("diag", 0, 0, 3, 3, 4, 3, 1'b0);

    // Steep line exercising the y-only step in the negative x direction.
    exp_px[0] = pk(12, 0); exp_px[1] = pk(11, 1); exp_px[2] = pk(11, 2);
    exp_px[3] = pk(10, 3);
    run_line("steep", 12, 0, 10, 3, 4, 3, 1'b0);

    // Reverse horizontal; end point and enable change mid-DRAW.
    exp_px[0] = pk(9, 4); exp_px[1] = pk(8, 4); exp_px[2] = pk(7, 4);
    exp_px[3] = pk(6, 4);
    run_line("rhoriz_chg", 9, 4, 6, 4, 4, 3, 1'b1);
    @(negedge clk);
    check_val("exit.busy", {31'd0, busy}, 32'd0);
    check_val("exit.pv", {31'd0, pixel_valid}, 32'd0);
    check_val("exit.x_hold", {21'd0, x}, 32'd6);
    check_val("exit.y_hold", {21'd0, y}, 32'd4);
    @(negedge clk);
    check_val("idle_stay.busy", {31'd0, busy}, 32'd0);

    // Reset in the third DRAW cycle of (0,0)->(0,9).
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd0; y1 = 11'd9;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check_val("pre_rst.y", {21'd0, y}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check_val("midrst.x", {21'd0, x}, 32'd0);
    check_val("midrst.y", {21'd0, y}, 32'd0);
    check_val("midrst.pv", {31'd0, pixel_valid}, 32'd0);
    check_val("midrst.busy", {31'd0, busy}, 32'd0);
    check_val("midrst.done", {31'd0, line_done}, 32'd0);
    @(negedge clk);
    check_val("midrst.done2", {31'd0, line_done}, 32'd0);
    @(negedge clk);
    check_val("midrst.done3", {31'd0, line_done}, 32'd0);
    reset = 1'b1;

    exp_px[0] = pk(0, 0); exp_px[1] = pk(0, 1); exp_px[2] = pk(0, 2);
    run_line("post_rst", 0, 0, 0, 2, 3, 2, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check_val("final.busy", {31'd0, busy}, 32'd0);
    check_val("final.done", {31'd0, line_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
